mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter CLEAR_VALUE, default 8'h00, is the byte written to every location during the post-reset clear.
REQ-002 Parameter DO_CLEAR, default 1; when 0 the block skips CLEAR and enters RUN directly after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr  input  8  CPU bus address.
REQ-006 data_in  input  8  CPU write data (driven from CPU data_out).
REQ-007 we  input  1  CPU write enable.
REQ-008 data_out  output  8  read data to CPU (drives CPU data_in).
REQ-009 load_start  input  1  single-cycle pulse requesting a program load.
REQ-010 load_len  input  8  byte count, sampled on an accepted load_start; 0 means 256.
REQ-011 load_valid  input  1  load byte present on load_data.
REQ-012 load_data  input  8  load byte.
REQ-013 load_ready  output  1  load byte accepted when load_valid and load_ready are both high.
REQ-014 load_done  output  1  one-cycle pulse after the last load byte is written.
REQ-015 busy  output  1  high in CLEAR and LOAD; CPU holds off while high.

Function
REQ-016 The block SHALL store 256 x 8 bits, one location per addr value.
REQ-017 States SHALL be CLEAR, RUN, LOAD.
REQ-018 CLEAR: ptr counts 0..255, one write of CLEAR_VALUE per cycle, 256 cycles total; when ptr=255 is written, go to RUN.
REQ-019 RUN: if we=1, mem[addr] <= data_in at the edge; data_out <= mem[addr] every edge (one-cycle read latency).
REQ-020 Read-during-write to the same address SHALL return the old contents (read-first).
REQ-021 RUN and load_start=1: latch load_len, ptr <= 0, go to LOAD next cycle; a CPU write in that same cycle SHALL still complete.
REQ-022 load_start outside RUN SHALL be ignored.
REQ-023 LOAD: load_ready=1; on each handshake, mem[ptr] <= load_data, ptr <= ptr+1 (8-bit wrap).
REQ-024 LOAD: the byte accepted with remaining count 1 SHALL be the last; load_done pulses the following cycle, coincident with return to RUN.
REQ-025 load_len=0 SHALL load 256 bytes, ptr wrapping 255->0, ending with ptr=0.
REQ-026 load_valid=0 in LOAD SHALL stall with no write and no count change, for any duration.
REQ-027 In CLEAR and LOAD, CPU we SHALL be ignored and data_out SHALL be 8'h00.
REQ-028 load_ready SHALL be 0 outside LOAD; busy SHALL equal (state != RUN).

Reset
REQ-029 rst=1 at an edge SHALL set state to CLEAR (RUN if DO_CLEAR=0), ptr=0, data_out=8'h00, load_ready=0, load_done=0.
REQ-030 busy after reset SHALL be 1 with DO_CLEAR=1, 0 with DO_CLEAR=0.
REQ-031 Reset during LOAD or CLEAR SHALL abandon the operation with no load_done; memory contents are rewritten only by the subsequent CLEAR.
REQ-032 Reset SHALL take priority over load_start, we and load handshakes in the same cycle.

Structure
REQ-033 Shared package bf8b_pkg SHALL hold ADDR_W=8, DATA_W=8 and the CLEAR/RUN/LOAD state encoding.
REQ-034 Storage SHALL be a sub-module mem_array: 256x8, one synchronous write port, one synchronous read-first read port.
REQ-035 The FSM, ptr, remaining-count and write-port muxing SHALL live in mem_responder.

Verification
REQ-036 Reset with DO_CLEAR=1 -> busy high exactly 256 cycles, then any RUN read returns 8'h00.
REQ-037 RUN: write 8'hA5 to 8'h10, read 8'h10 next cycle -> data_out=8'hA5 one cycle after addr applied; same-cycle read/write to 8'h11 returns old value.
REQ-038 load_start with load_len=3, bytes 8'h01,8'h02,8'h03 with one load_valid gap -> mem[0..2]=01,02,03, load_done single pulse, busy low afterward.
REQ-039 load_len=0, 256 bytes (value = index) -> all 256 locations match, ptr wraps to 0, exactly one load_done.
REQ-040 CPU we=1 to 8'h05 with 8'hFF during LOAD -> mem[5] unchanged, data_out=8'h00 while busy.
REQ-041 rst asserted after 2 of 5 load bytes -> no load_done, CLEAR runs 256 cycles, mem[0]=CLEAR_VALUE.

Source files
------------

// File: rtl/bf8b_pkg.sv
// rtl/bf8b_pkg.sv - shared widths and FSM state encoding for mem_responder
package bf8b_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - 256x8 storage, one synchronous write port, one read-first read port
module mem_array
    import bf8b_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports in one block: a same-address read sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU-facing memory with post-reset clear and streamed program load
module mem_responder
    import bf8b_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00,
    parameter bit                DO_CLEAR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    output logic [DATA_W-1:0] data_out,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] remaining;
    logic              rd_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = CLEAR_VALUE;
            end
            ST_RUN:   mem_we = we;
            ST_LOAD: begin
                mem_we    = load_valid;
                mem_waddr = ptr;
                mem_wdata = load_data;
            end
            default:  mem_we = 1'b0;
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    mem_array u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (mem_wdata),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    // remaining==0 encodes 256 bytes: it wraps to 255 and hits 1 on the 256th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DO_CLEAR ? ST_CLEAR : ST_RUN;
            ptr        <= '0;
            remaining  <= '0;
            rd_valid   <= 1'b0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            busy       <= DO_CLEAR;
        end else begin
            load_done <= 1'b0;
            rd_valid  <= (state == ST_RUN) && !load_start;
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        remaining  <= load_len;
                        ptr        <= '0;
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 8'd1) begin
                            state      <= ST_RUN;
                            busy       <= 1'b0;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    busy       <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Only reads issued from RUN reach the bus; everything else reads as zero.
    assign data_out = rd_valid ? rd_data : '0;
endmodule
